// File: rtl/rbm_hidden_sampler.sv
// rbm_hidden_sampler: Bernoulli sampler for the RBM hidden layer.
// Draws h = (p_j > r) per probability, with r taken from a 32-bit Galois
// LFSR, and packs H_DIM samples into h_vec for the reconstruction pass.
// Optional build macro RBM_HSAMP_PROB_STORE_EN adds an H_DIM x 16 RAM
// that keeps every accepted probability for mean-field readback.
module rbm_hidden_sampler #(
    parameter int          H_DIM     = 64,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_1234
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    output logic                       busy_o,
    input  logic                       p_valid_i,
    output logic                       p_ready_o,
    input  logic [15:0]                p_j_i,
    input  logic                       seed_load_i,
    input  logic [31:0]                seed_i,
    output logic [H_DIM-1:0]           h_vec_o,
    output logic                       h_valid_o,
`ifdef RBM_HSAMP_PROB_STORE_EN
    input  logic [$clog2(H_DIM)-1:0]   prob_rd_addr_i,
    output logic [15:0]                prob_rd_data_o,
`endif
    output logic [$clog2(H_DIM+1)-1:0] count_o
);

    localparam int          CW        = $clog2(H_DIM + 1);
    localparam int          IW        = $clog2(H_DIM);
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [31:0]      lfsr_q, lfsr_d, lfsr_adv;
    logic [H_DIM-1:0] h_vec_q, h_vec_d;
    logic [CW-1:0]    count_q, count_d;
    logic             accept, last_beat, sample;
    logic [IW-1:0]    idx;

    // p_ready only asserts in COLLECT, so an accept implies COLLECT.
    assign accept    = p_valid_i && p_ready_o;
    assign last_beat = (count_q == CW'(H_DIM - 1));
    assign idx       = count_q[IW-1:0];
    assign sample    = (p_j_i > lfsr_q[15:0]);
    assign lfsr_adv  = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_MASK : 32'h0);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; start outside IDLE is deliberately ignored
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start_i) state_d = S_COLLECT;
            S_COLLECT: if (accept && last_beat) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the state register only
    always_comb begin
        p_ready_o = (state_q == S_COLLECT);
        h_valid_o = (state_q == S_DONE);
        busy_o    = (state_q == S_COLLECT) || (state_q == S_DONE);
    end

    // Datapath next state: a seed load overrides the advance, but the
    // coincident sample has already used the pre-load r
    always_comb begin
        h_vec_d = h_vec_q;
        count_d = count_q;
        lfsr_d  = lfsr_q;
        if (state_q == S_IDLE && start_i) begin
            h_vec_d = '0;
            count_d = '0;
        end else if (accept) begin
            h_vec_d[idx] = sample;
            count_d      = count_q + CW'(1);
        end
        if (seed_load_i)  lfsr_d = (seed_i == 32'h0) ? LFSR_SEED : seed_i;
        else if (accept)  lfsr_d = lfsr_adv;
    end

    // Datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q  <= LFSR_SEED;
            h_vec_q <= '0;
            count_q <= '0;
        end else begin
            lfsr_q  <= lfsr_d;
            h_vec_q <= h_vec_d;
            count_q <= count_d;
        end
    end

    assign h_vec_o = h_vec_q;
    assign count_o = count_q;

`ifdef RBM_HSAMP_PROB_STORE_EN
    logic [15:0] prob_mem [H_DIM];
    logic [15:0] prob_rd_q;

    // Probability RAM write, indexed like the h_vec bit
    always_ff @(posedge clk_i) begin
        if (accept) prob_mem[idx] <= p_j_i;
    end

    // Registered read port, one-cycle latency
    always_ff @(posedge clk_i) begin
        if (rst_i) prob_rd_q <= 16'h0;
        else       prob_rd_q <= prob_mem[prob_rd_addr_i];
    end

    assign prob_rd_data_o = prob_rd_q;
`endif

endmodule

// File: doc/rbm_hidden_sampler.md
# rbm_hidden_sampler

Downstream stage of the single-unit RBM hidden-layer core. Consumes the stream of sigmoid probabilities p_j (Q0.16) produced per hidden unit. Draws one Bernoulli sample per probability using an internal 32-bit LFSR and packs the resulting binary hidden states into an H_DIM-bit vector for the negative-phase (reconstruction) pass. Runs one vector per `start`, with a valid/ready input handshake and a single-cycle completion strobe.

## Interface
- `H_DIM`, 64: hidden units per vector; must be ≥ 2.
- `LFSR_SEED`, 32'hACE1_1234: LFSR value after reset; also substituted whenever a zero seed is loaded.

- `clk` input 1: single clock, all logic rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: single-cycle pulse; begins a new vector from IDLE.
- `busy` output 1: high in COLLECT and DONE.
- `p_valid` input 1: `p_j` holds a valid probability.
- `p_ready` output 1: sampler accepts `p_j` this cycle.
- `p_j` input 16: probability, unsigned Q0.16.
- `seed_load` input 1: load `seed` into the LFSR.
- `seed` input 32: LFSR seed value.
- `h_vec` output H_DIM: packed samples; bit i is hidden unit i.
- `h_valid` output 1: one-cycle strobe when `h_vec` is complete.
- `count` output $clog2(H_DIM+1): samples accepted in the current vector.

## Operation
- **Reset:** state=IDLE; `lfsr`=LFSR_SEED. `busy`, `p_ready`, `h_valid`, `h_vec`, and `count` are all 0.
- **LFSR:** 32-bit Galois, polynomial x^32+x^22+x^2+x+1 (mask 32'h8020_0003). Shifts right; if the old bit0 is 1, the mask is XORed in.
  - Advances exactly once per accepted sample, never otherwise.
  - Random value r = lfsr[15:0], taken from the value before the advance.
- **Sample rule:** h = (p_j > r), unsigned 16-bit compare.
  - p_j=0 always yields 0.
  - p_j=0xFFFF yields 1 unless r=0xFFFF.
- **IDLE:** `p_ready`=0.
  - On `start`: go to COLLECT, clear `h_vec` and `count`.
- **COLLECT:** `p_ready`=1. On accept (`p_valid` & `p_ready`):
  - write `h_vec[count]` = h;
  - increment `count`;
  - advance the LFSR.
  - The accept that brings `count` to H_DIM moves the state to DONE.
- **DONE:** `h_valid`=1 and `p_ready`=0 for exactly one cycle, then IDLE.
  - `h_vec` and `count` (=H_DIM) hold until the next `start` or `rst`.
- **`start` while not IDLE:** ignored. No abort, no restart.
- **`seed_load`:** honoured in any state.
  - Next cycle, `lfsr` = `seed`, or LFSR_SEED if `seed`==0.
  - If it coincides with an accept, the sample uses the pre-load r, and the load wins over the advance.
- **`rst` mid-vector:** partial `h_vec` is discarded. All state returns to reset values, and the LFSR reseeds to LFSR_SEED.

## Timing
- `p_ready` is a registered function of state only. It does not depend on `p_valid` combinationally.
- Throughput: 1 sample per cycle while `p_valid` is held high.
- `start` → `p_ready` high: 1 cycle.
- Last accept → `h_valid`: next cycle.
- Minimum vector time from `start`: H_DIM + 2 cycles.
- `h_vec[i]` is visible the cycle after its accept.
- `count` updates in the same cycle as the `h_vec` write.

## Configuration
- Macro: `RBM_HSAMP_PROB_STORE_EN`.
- **Defined:** adds an internal H_DIM×16 probability RAM that stores every accepted `p_j` at index `count`. Adds ports:
  - `prob_rd_addr` input $clog2(H_DIM);
  - `prob_rd_data` output 16, registered, 1-cycle read latency, reset value 0.
  - Mean-field consumers read it after `h_valid`. Contents persist until overwritten.
- **Undefined:** no RAM and no extra ports. Sampling behaviour is identical in both builds.

## Test plan
- **Reset values:** assert `rst` 5 cycles → all outputs 0.
  - Then `start` with `p_j`=0x0000 for 64 accepts → `h_valid` one cycle, `h_vec`=0, `count`=64.
- **Known seed:** `seed_load` with `seed`=32'h0000_0001, then 64 samples of `p_j`=0xFFFF with `p_valid` toggled randomly.
  - `h_vec` matches the bench LFSR reference model bit-for-bit.
  - The LFSR advances only on accepted beats.
- **Statistics:** 64 vectors with `p_j`=0x4000 → total ones 1024 ± 96 out of 4096.
  - Repeat with `p_j`=0xC000 → 3072 ± 96.
- **Illegal start / zero seed:** `start` pulses during COLLECT and DONE → no effect on `count` or `h_vec`.
  - `seed_load` with `seed`=0 → LFSR = 32'hACE1_1234 next cycle.
- **Collisions:** `seed_load` coincident with accept #10 → sample 10 uses the old r, and sample 11 uses r from the loaded seed.
  - `rst` asserted at `count`=30 → `busy`=0, `count`=0, `h_vec`=0 the next cycle.
- **`RBM_HSAMP_PROB_STORE_EN` build:** `p_j`=i×0x0100 for i=0..63 → after `h_valid`, reading address 37 returns 0x2500 one cycle later.
